// File: rtl/pio_sequencer.sv
// PIO access sequencer: arbitrates a register port and a data port onto one
// PIO timing controller, with an optional IORDY timeout per access.
module pio_sequencer #(
    parameter int TWIDTH  = 8,
    parameter int DWIDTH  = 16,
    parameter int TOWIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                req0,
    input  logic                we0,
    input  logic [3:0]          adr0,
    input  logic [DWIDTH-1:0]   dat0_i,
    input  logic [4*TWIDTH-1:0] tim0,
    output logic                ack0,
    output logic                err0,

    input  logic                req1,
    input  logic                we1,
    input  logic [3:0]          adr1,
    input  logic [DWIDTH-1:0]   dat1_i,
    input  logic [4*TWIDTH-1:0] tim1,
    output logic                ack1,
    output logic                err1,

    output logic [DWIDTH-1:0]   rdat_o,

    input  logic                to_en,
    input  logic [TOWIDTH-1:0]  to_limit,

    output logic                pio_go,
    output logic                pio_we,
    output logic                pio_rst,
    output logic [TWIDTH-1:0]   pio_T1,
    output logic [TWIDTH-1:0]   pio_T2,
    output logic [TWIDTH-1:0]   pio_T4,
    output logic [TWIDTH-1:0]   pio_Teoc,
    output logic [3:0]          pio_adr,
    output logic [DWIDTH-1:0]   pio_dout,
    input  logic [DWIDTH-1:0]   pio_din,
    input  logic                pio_done,
    input  logic                pio_dstrb
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACK, ABORT} state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 gnt;
    logic                 last_gnt;
    logic [TOWIDTH-1:0]   cnt;

    logic                 sel;
    logic                 sel_we;
    logic [3:0]           sel_adr;
    logic [DWIDTH-1:0]    sel_dat;
    logic [4*TWIDTH-1:0]  sel_tim;

    // Counter sticks at all-ones so a long wait can never alias a small limit.
    function automatic logic [TOWIDTH-1:0] sat_inc(input logic [TOWIDTH-1:0] v);
        return (&v) ? v : v + {{(TOWIDTH-1){1'b0}}, 1'b1};
    endfunction

    always_comb begin
        sel     = (req0 && req1) ? ~last_gnt : req1;
        sel_we  = sel ? we1    : we0;
        sel_adr = sel ? adr1   : adr0;
        sel_dat = sel ? dat1_i : dat0_i;
        sel_tim = sel ? tim1   : tim0;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req0 || req1) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT: begin
                if (pio_done)                      state_nxt = ACK;
                else if (to_en && cnt == to_limit) state_nxt = ABORT;
            end
            ACK:     state_nxt = IDLE;
            ABORT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pio_go  = (state == ISSUE);
        pio_rst = (state == ABORT);
        ack0    = (state == ACK || state == ABORT) && !gnt;
        ack1    = (state == ACK || state == ABORT) &&  gnt;
        err0    = (state == ABORT) && !gnt;
        err1    = (state == ABORT) &&  gnt;
    end

    // Bus-side fields are captured only on grant and then held, which keeps
    // address and write data stable through the controller's Teoc phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt      <= 1'b0;
            last_gnt <= 1'b1;
            pio_we   <= 1'b0;
            pio_adr  <= '0;
            pio_dout <= '0;
            pio_T1   <= '0;
            pio_T2   <= '0;
            pio_T4   <= '0;
            pio_Teoc <= '0;
            cnt      <= '0;
            rdat_o   <= '0;
        end else begin
            if (state == IDLE && (req0 || req1)) begin
                gnt      <= sel;
                last_gnt <= sel;
                pio_we   <= sel_we;
                pio_adr  <= sel_adr;
                pio_dout <= sel_dat;
                pio_T1   <= sel_tim[TWIDTH-1:0];
                pio_T2   <= sel_tim[2*TWIDTH-1:TWIDTH];
                pio_T4   <= sel_tim[3*TWIDTH-1:2*TWIDTH];
                pio_Teoc <= sel_tim[4*TWIDTH-1:3*TWIDTH];
            end
            if (state == ISSUE)
                cnt <= '0;
            else if (state == WAIT && !pio_done)
                cnt <= sat_inc(cnt);
            if (state == WAIT && pio_dstrb && !pio_we)
                rdat_o <= pio_din;
        end
    end

endmodule

// File: tb/tb_pio_sequencer.sv
// Bench for pio_sequencer: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level timing model.
module tb_pio_sequencer;
    localparam int TW   = 8;
    localparam int DW   = 16;
    localparam int TOW  = 4;
    localparam int MAXC = (1 << TOW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, req0, req1, we0, we1;
    logic [3:0] adr0, adr1;
    logic [DW-1:0] dat0_i, dat1_i;
    logic [4*TW-1:0] tim0, tim1;
    logic ack0, ack1, err0, err1;
    logic [DW-1:0] rdat_o;
    logic to_en;
    logic [TOW-1:0] to_limit;
    logic pio_go, pio_we, pio_rst;
    logic [TW-1:0] pio_T1, pio_T2, pio_T4, pio_Teoc;
    logic [3:0] pio_adr;
    logic [DW-1:0] pio_dout, pio_din;
    logic pio_done, pio_dstrb;

    pio_sequencer #(.TWIDTH(TW), .DWIDTH(DW), .TOWIDTH(TOW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .adr0(adr0), .dat0_i(dat0_i), .tim0(tim0), .ack0(ack0), .err0(err0),
        .req1(req1), .we1(we1), .adr1(adr1), .dat1_i(dat1_i), .tim1(tim1), .ack1(ack1), .err1(err1),
        .rdat_o(rdat_o), .to_en(to_en), .to_limit(to_limit),
        .pio_go(pio_go), .pio_we(pio_we), .pio_rst(pio_rst),
        .pio_T1(pio_T1), .pio_T2(pio_T2), .pio_T4(pio_T4), .pio_Teoc(pio_Teoc),
        .pio_adr(pio_adr), .pio_dout(pio_dout), .pio_din(pio_din),
        .pio_done(pio_done), .pio_dstrb(pio_dstrb)
    );

    // Stimulus intent, copied onto the DUT pins at each falling edge
    logic d_rst;
    logic [1:0] d_req;
    logic d_we [2];
    logic [3:0] d_adr [2];
    logic [DW-1:0] d_dat [2];
    logic [4*TW-1:0] d_tim [2];
    logic d_done, d_dstrb, d_to_en;
    logic [DW-1:0] d_din;
    logic [TOW-1:0] d_to_lim;

    // Transaction-level model: timestamps of the current access
    int cyc = 0;
    bit busy = 0, ended = 0, ab = 0;
    int gnt_m = 0, last_m = 1, go_cyc = 0, end_cyc = 0, k = 0;
    logic e_go, e_prst, e_we;
    logic [1:0] e_ack, e_err;
    logic [3:0] e_adr;
    logic [DW-1:0] e_dout, e_rdat;
    logic [4*TW-1:0] e_tim;
    bit chk_on = 0;
    int total = 0, bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_on) begin
            chk("strobes", {pio_go, pio_rst, ack0, err0, ack1, err1},
                {e_go, e_prst, e_ack[0], e_err[0], e_ack[1], e_err[1]});
            chk("pio_regs", {pio_we, pio_adr, pio_dout, pio_Teoc, pio_T4, pio_T2, pio_T1},
                {e_we, e_adr, e_dout, e_tim});
            chk("rdat", rdat_o, e_rdat);
        end
    end

    task automatic new_fields(input int n);
        d_we[n]  = 1'($urandom % 2);
        d_adr[n] = 4'($urandom);
        d_dat[n] = DW'($urandom);
        d_tim[n] = (4*TW)'($urandom);
    endtask

    // One clock: drive the intent, then predict the outputs of the next cycle.
    task automatic step();
        int j, el, w;
        @(negedge clk);
        cyc++;
        rst = d_rst; req0 = d_req[0]; req1 = d_req[1];
        we0 = d_we[0]; we1 = d_we[1]; adr0 = d_adr[0]; adr1 = d_adr[1];
        dat0_i = d_dat[0]; dat1_i = d_dat[1]; tim0 = d_tim[0]; tim1 = d_tim[1];
        pio_done = d_done; pio_dstrb = d_dstrb; pio_din = d_din;
        to_en = d_to_en; to_limit = d_to_lim;
        e_go = 0; e_prst = 0; e_ack = 2'b00; e_err = 2'b00;
        if (d_rst) begin
            busy = 0; ended = 0; last_m = 1;
            e_we = 0; e_adr = '0; e_dout = '0; e_tim = '0; e_rdat = '0;
            chk_on = 1;
        end else if (busy && !ended && cyc > go_cyc) begin
            j  = cyc - go_cyc - 1;
            el = (j > MAXC) ? MAXC : j;
            if (d_dstrb && !e_we) e_rdat = d_din;
            if (d_done) begin
                ended = 1; ab = 0; end_cyc = cyc + 1;
            end else if (d_to_en && el == int'(d_to_lim)) begin
                ended = 1; ab = 1; end_cyc = cyc + 1;
            end
            if (ended) begin
                e_ack[gnt_m] = 1'b1; e_err[gnt_m] = ab; e_prst = ab;
            end
        end else if (busy && ended && cyc == end_cyc) begin
            busy = 0;
        end else if (!busy && d_req != 2'b00) begin
            w = (d_req == 2'b11) ? ((last_m == 0) ? 1 : 0) : (d_req[1] ? 1 : 0);
            gnt_m = w; last_m = w; busy = 1; ended = 0; go_cyc = cyc + 1;
            e_go = 1; e_we = d_we[w]; e_adr = d_adr[w]; e_dout = d_dat[w]; e_tim = d_tim[w];
        end
        @(posedge clk);
        #2;
    endtask

    task automatic rnd_drive();
        int u;
        u = cyc + 1;
        d_rst = 0;
        for (int n = 0; n < 2; n++) begin
            if (busy && ended && u == end_cyc && gnt_m == n) begin
                d_req[n] = 1'($urandom % 2);
                if (d_req[n]) new_fields(n);
            end else if (!d_req[n] && ($urandom % 4 == 0)) begin
                d_req[n] = 1'b1;
                new_fields(n);
            end
        end
        d_done  = busy && !ended && (u > go_cyc) && ((u - go_cyc - 1) == k);
        d_dstrb = ($urandom % 3 == 0);
        d_din   = DW'($urandom);
        if (!busy) begin
            d_to_en  = 1'($urandom % 2);
            d_to_lim = TOW'($urandom % 13);
            k = ($urandom % 8 == 0) ? 1000 : int'($urandom % 16);
            if (k == 1000) d_to_en = 1'b1;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nack, n;
        logic [3:0] seq;
        logic any_ack;
        d_rst = 1; d_req = 2'b00; d_done = 0; d_dstrb = 0; d_din = '0;
        d_to_en = 0; d_to_lim = '0;
        for (int i = 0; i < 2; i++) begin
            d_we[i] = 0; d_adr[i] = '0; d_dat[i] = '0; d_tim[i] = '0;
        end
        step(); step();
        chk("rst_strobes", {pio_go, pio_rst, ack0, err0, ack1, err1}, 6'b0);
        chk("rst_regs", {pio_we, pio_adr, pio_dout}, 21'h0);
        chk("rst_tim", {pio_Teoc, pio_T4, pio_T2, pio_T1}, 32'h0);
        chk("rst_rdat", rdat_o, 16'h0);
        d_rst = 0;

        // Both requesters held high: grants must alternate starting at 0
        d_req = 2'b11; d_we[0] = 1; d_we[1] = 1; d_adr[0] = 4'h1; d_adr[1] = 4'h2;
        d_done = 1; nack = 0; seq = 4'h0;
        for (int i = 0; i < 24 && nack < 4; i++) begin
            step();
            if (ack0 || ack1) begin seq[3-nack] = ack1; nack++; end
        end
        chk("arb_count", nack, 4);
        chk("arb_order", seq, 4'b0101);
        d_req = 2'b00; d_done = 0;
        step();

        // Write on port 0
        d_req = 2'b01; d_we[0] = 1; d_adr[0] = 4'h7; d_dat[0] = 16'h00EC; d_tim[0] = 32'h04030201;
        step();
        chk("wr_go", pio_go, 1'b1);
        chk("wr_bus", {pio_we, pio_adr, pio_dout}, {1'b1, 4'h7, 16'h00EC});
        chk("wr_tim", {pio_Teoc, pio_T4, pio_T2, pio_T1}, 32'h04030201);
        step();
        chk("wr_go_once", pio_go, 1'b0);
        step();
        d_done = 1; step();
        chk("wr_ack", {ack0, err0, ack1, err1, pio_rst}, 5'b10000);
        d_done = 0; d_req = 2'b00; step();
        chk("wr_hold", {ack0, pio_adr, pio_dout}, {1'b0, 4'h7, 16'h00EC});

        // Read on port 1
        d_req = 2'b10; d_we[1] = 0; d_adr[1] = 4'h8; d_dat[1] = 16'h1234; d_tim[1] = 32'h11223344;
        step();
        chk("rd_go", {pio_go, pio_we, pio_adr}, {1'b1, 1'b0, 4'h8});
        step();
        d_dstrb = 1; d_din = 16'hA55A; step();
        d_dstrb = 0; d_done = 1; step();
        chk("rd_ack", {ack1, err1, ack0}, 3'b100);
        chk("rd_data", rdat_o, 16'hA55A);
        d_done = 0; d_req = 2'b00; step();

        // Timeout on a write, with data strobes that must not touch rdat_o
        d_req = 2'b01; d_we[0] = 1; d_to_en = 1; d_to_lim = 4'd10; d_dstrb = 1; d_din = 16'hFFFF;
        step();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step(); n++;
            if (ack0) break;
        end
        chk("to_latency", n, 12);
        chk("to_strobes", {ack0, err0, pio_rst, ack1, err1}, 5'b11100);
        chk("to_rdat", rdat_o, 16'hA55A);
        d_req = 2'b00; d_dstrb = 0; step();
        chk("to_idle", {ack0, err0, pio_rst, pio_go}, 4'b0);

        // pio_done arriving exactly at the limit wins over the timeout
        d_req = 2'b10; d_we[1] = 0; d_to_lim = 4'd3;
        step();
        chk("race_go", pio_go, 1'b1);
        step(); step(); step(); step();
        d_done = 1; step();
        chk("race_ack", {ack1, err1, pio_rst}, 3'b100);
        d_done = 0; d_req = 2'b00; step();

        // Zero limit aborts in the first wait cycle
        d_req = 2'b01; d_to_lim = 4'd0;
        step(); step(); step();
        chk("lim0_abort", {ack0, err0, pio_rst}, 3'b111);
        d_req = 2'b00; step();

        // Long wait without timeout, then enable at the saturated count
        d_req = 2'b01; d_to_en = 0; d_to_lim = 4'd15;
        step(); step();
        any_ack = 0;
        for (int i = 0; i < 30; i++) begin step(); any_ack |= ack0 | ack1; end
        chk("sat_no_ack", any_ack, 1'b0);
        d_to_en = 1; step();
        chk("sat_abort", {ack0, err0}, 2'b11);
        d_req = 2'b00; d_to_en = 0; step();

        // Reset in the middle of a wait
        d_req = 2'b01; d_we[0] = 1; d_adr[0] = 4'h3; d_dat[0] = 16'hBEEF;
        step(); step(); step();
        d_rst = 1; step();
        chk("mid_rst_out", {pio_go, pio_rst, ack0, err0, ack1, err1, pio_we, pio_adr, pio_dout}, 27'h0);
        chk("mid_rst_rdat", rdat_o, 16'h0);
        d_rst = 0; d_req = 2'b00; d_done = 1;
        any_ack = 0;
        for (int i = 0; i < 6; i++) begin step(); any_ack |= ack0 | ack1; end
        chk("mid_rst_no_ack", any_ack, 1'b0);
        d_done = 0;

        for (int i = 0; i < 3000; i++) begin
            rnd_drive();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pio_sequencer.md
PIO_SEQUENCER -- requirements
Module: pio_sequencer

Interface
REQ-001 SHALL have parameter TWIDTH, default 8, width of each timing field.
REQ-002 SHALL have parameter DWIDTH, default 16, ATA data-bus width.
REQ-003 SHALL have parameter TOWIDTH, default 16, width of the timeout counter.
REQ-004 SHALL have port clk  in  1  master clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports reqN  in  1  access request from requester N (N=0 register port, N=1 data port).
REQ-007 SHALL have ports weN  in  1  requester N direction (1 = write, 0 = read).
REQ-008 SHALL have ports adrN  in  4  requester N ATA address {CS1,DA[2:0]}.
REQ-009 SHALL have ports datN_i  in  DWIDTH  requester N write data.
REQ-010 SHALL have ports timN  in  4*TWIDTH  requester N timing set {Teoc,T4,T2,T1}.
REQ-011 SHALL have ports ackN  out  1  one-cycle completion strobe to requester N.
REQ-012 SHALL have ports errN  out  1  one-cycle timeout strobe, coincident with ackN.
REQ-013 SHALL have port rdat_o  out  DWIDTH  last read data, shared by both requesters.
REQ-014 SHALL have port to_en  in  1  enable IORDY timeout.
REQ-015 SHALL have port to_limit  in  TOWIDTH  timeout in clk cycles.
REQ-016 SHALL have ports pio_go / pio_we / pio_rst  out  1  go strobe, direction and abort reset to the PIO timing controller.
REQ-017 SHALL have ports pio_T1 / pio_T2 / pio_T4 / pio_Teoc  out  TWIDTH  timing values to the timing controller.
REQ-018 SHALL have ports pio_adr (out 4), pio_dout (out DWIDTH), pio_din (in DWIDTH), pio_done (in 1), pio_dstrb (in 1).

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT, ACK, ABORT.
REQ-020 IDLE: if any reqN is high, SHALL grant, latch weN/adrN/datN_i/timN of the winner into registers driving pio_*, and go to ISSUE.
REQ-021 Arbitration SHALL be round-robin: with both requests high, the requester not granted last wins; the last-grant pointer updates only on grant.
REQ-022 ISSUE: SHALL drive pio_go=1 for exactly this one cycle, clear the timeout counter, and go to WAIT; pio_go is therefore high in the cycle after the request is sampled.
REQ-023 WAIT: on pio_done=1 SHALL go to ACK; otherwise the timeout counter increments by 1 per cycle.
REQ-024 WAIT: with to_en=1 and counter==to_limit and pio_done=0, SHALL go to ABORT; pio_done SHALL win if both occur in the same cycle.
REQ-025 With to_limit=0 and to_en=1, SHALL abort in the first WAIT cycle unless pio_done is high in that cycle.
REQ-026 The counter SHALL saturate at all-ones and never wrap; with to_en=0, WAIT lasts indefinitely.
REQ-027 ACK: SHALL assert ackN of the granted requester for one cycle, then go to IDLE.
REQ-028 ABORT: SHALL assert ackN, errN and pio_rst for one cycle, then go to IDLE.
REQ-029 On pio_dstrb=1 while in WAIT with a read grant, SHALL register pio_din into rdat_o; rdat_o SHALL otherwise hold, including on writes and aborts.
REQ-030 pio_adr, pio_we, pio_dout and pio_T* SHALL stay stable from grant until the next grant, preserving address and data hold through Teoc.
REQ-031 reqN SHALL be held until ackN; a reqN still high in the cycle after ackN SHALL be treated as a new request.
REQ-032 Only one ackN/errN pair SHALL ever be active in a cycle, and never for the non-granted requester.

Reset
REQ-033 rst=1 SHALL force state IDLE, ack*/err*/pio_go/pio_rst=0, pio_we=0, pio_adr=0, pio_dout=0, pio_T*=0, rdat_o=0, counter=0, and the pointer such that requester 0 wins the first tie.
REQ-034 rst asserted mid-transfer SHALL abandon it with no ack; pio_rst is not asserted, because the timing controller shares rst.

Verification
REQ-035 Write: req0=1, we0=1, adr0=4'h7, dat0_i=16'h00EC -> pio_go high 1 cycle later with pio_adr=7, pio_dout=16'h00EC, pio_we=1; pio_done pulse -> ack0 on the next cycle, err0=0.
REQ-036 Read: req1, we1=0, pio_din=16'hA55A with pio_dstrb -> rdat_o=16'hA55A, ack1 one cycle after pio_done.
REQ-037 Arbitration: req0 and req1 held high continuously -> grants alternate 0,1,0,1 starting with 0 after reset.
REQ-038 Timeout: to_en=1, to_limit=10, pio_done never asserted -> ack/err/pio_rst high together in one cycle, rdat_o unchanged, FSM back in IDLE.
REQ-039 Race: pio_done in the same cycle the counter equals to_limit -> normal ack, no err, no pio_rst.
REQ-040 rst pulse during WAIT -> all outputs return to reset values next cycle, no ack ever issued for that transfer.
